// File: rtl/speed_cmd_pkg.sv
// speed_cmd_pkg: shared types and constants for the wheel-speed command interface (issuer and display)
package speed_cmd_pkg;
    typedef enum logic [1:0] {
        INSTR_FWD   = 2'd0,
        INSTR_BACK  = 2'd1,
        INSTR_LEFT  = 2'd2,
        INSTR_RIGHT = 2'd3
    } instr_t;

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_PULSE, S_GAP} issuer_state_t;

    localparam logic [2:0] TORQUE_MAX = 3'd4;

    function automatic logic [2:0] sat_torque(input logic [2:0] t);
        return (t > TORQUE_MAX) ? TORQUE_MAX : t;
    endfunction
endpackage

// File: rtl/speed_cmd_issuer_if.sv
// speed_cmd_issuer_if: command bus from the issuer (master) to the display (slave)
interface speed_cmd_issuer_if;
    import speed_cmd_pkg::*;
    instr_t     instruction;
    logic [2:0] torque;
    logic       read_enable;
    logic       enable;
    logic       busy;
    modport master (output instruction, torque, read_enable, enable, busy);
    modport slave  (input  instruction, torque, read_enable, enable, busy);
endinterface

// File: rtl/req_conditioner.sv
// req_conditioner: 2-FF synchroniser for one request line, plus a debouncer when SPEED_CMD_DEBOUNCE_EN is defined
module req_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_req,
    output logic o_req
);
    logic [1:0] r_sync;

    // Bring the asynchronous request into the clk domain
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) r_sync <= '0;
        else          r_sync <= {r_sync[0], i_req};

`ifdef SPEED_CMD_DEBOUNCE_EN
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [DW-1:0] r_cnt;
    logic          r_out;

    // Follow the synchronised input only once it has differed from the output for DEBOUNCE_CYCLES cycles
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            r_cnt <= '0;
            r_out <= 1'b0;
        end else if (r_sync[1] == r_out) begin
            r_cnt <= '0;
        end else if (r_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
            r_out <= r_sync[1];
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end

    assign o_req = r_out;
`else
    assign o_req = r_sync[1];
`endif
endmodule

// File: rtl/speed_cmd_issuer.sv
// speed_cmd_issuer: issues {instruction, torque} commands with a read_enable strobe at a fixed cadence while a single direction is held; optional debounce via SPEED_CMD_DEBOUNCE_EN
module speed_cmd_issuer
    import speed_cmd_pkg::*;
#(
    parameter int TICK_CYCLES     = 50_000_000,
    parameter int PULSE_CYCLES    = 4,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      req_fwd,
    input  logic                      req_back,
    input  logic                      req_left,
    input  logic                      req_right,
    input  logic [2:0]                torque_sel,
    speed_cmd_issuer_if.master        cmd
);
    localparam int CW = $clog2(TICK_CYCLES + 1);

    logic [3:0]    w_raw;
    logic [3:0]    w_req;
    logic          w_valid;
    instr_t        w_instr;
    logic [2:0]    w_torque;

    issuer_state_t r_state;
    logic [CW-1:0] r_cnt;
    instr_t        r_instr;
    logic [2:0]    r_torque;
    logic          r_rd;
    logic          r_en;
    logic          r_busy;

    assign w_raw = {req_right, req_left, req_back, req_fwd};

    for (genvar g = 0; g < 4; g++) begin : g_cond
        req_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond (
            .clk     (clk),
            .reset_n (reset_n),
            .i_req   (w_raw[g]),
            .o_req   (w_req[g])
        );
    end

    // Bit index of the single active request is the instruction encoding
    assign w_valid  = $onehot(w_req);
    assign w_instr  = instr_t'({w_req[3] | w_req[2], w_req[3] | w_req[1]});
    assign w_torque = sat_torque(torque_sel);

    // Command FSM; the command word is captured on SETUP entry so it is stable for the whole SETUP cycle
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_instr  <= INSTR_FWD;
            r_torque <= '0;
            r_rd     <= 1'b0;
            r_en     <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_cnt <= (r_cnt == CW'(TICK_CYCLES)) ? r_cnt : r_cnt + 1'b1;
            case (r_state)
                S_IDLE:
                    if (w_valid) begin
                        r_state  <= S_SETUP;
                        r_cnt    <= '0;
                        r_instr  <= w_instr;
                        r_torque <= w_torque;
                        r_busy   <= 1'b1;
                    end
                S_SETUP: begin
                    r_state <= S_PULSE;
                    r_rd    <= 1'b1;
                    r_en    <= 1'b1;
                end
                S_PULSE:
                    if (r_cnt == CW'(PULSE_CYCLES)) begin
                        r_state <= S_GAP;
                        r_rd    <= 1'b0;
                    end
                S_GAP:
                    if (r_cnt == CW'(TICK_CYCLES - 1)) begin
                        if (w_valid) begin
                            r_state  <= S_SETUP;
                            r_cnt    <= '0;
                            r_instr  <= w_instr;
                            r_torque <= w_torque;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                default: r_state <= S_IDLE;
            endcase
        end

    assign cmd.instruction = r_instr;
    assign cmd.torque      = r_torque;
    assign cmd.read_enable = r_rd;
    assign cmd.enable      = r_en;
    assign cmd.busy        = r_busy;
endmodule
